// File: rtl/rover_display_sequencer.sv
// rover_display_sequencer
// Frame-synchronous update controller for the rover display path.
// Location/orientation updates and move commands arrive over valid/ready
// handshakes. They are held in shadow registers and committed together to
// the VGA writer once per vsync falling edge, so a frame never shows a mix
// of old and new data. The block also tracks how many frames have passed
// without a location refresh.
//
// Ports
//   vclock          : pixel clock
//   reset           : asynchronous, active-high, clears all state
//   loc_valid/ready : location handshake, carries loc_data (12b) + ori_data (6b)
//   cmd_valid/ready : move command handshake, carries cmd_data (12b)
//   target_sw       : raw asynchronous target switches (4b)
//   vsync           : active-low vertical sync, vclock domain
//   location, orientation, move_command, target_location : committed snapshot
//   new_data        : one-cycle pulse after a commit that changed anything
//   stale           : no location committed for STALE_FRAMES frames
//   overrun         : sticky, an uncommitted update was overwritten
module rover_display_sequencer #(
   parameter int unsigned STALE_FRAMES = 60
) (
   input  logic        vclock,
   input  logic        reset,
   input  logic        loc_valid,
   input  logic [11:0] loc_data,
   input  logic [5:0]  ori_data,
   output logic        loc_ready,
   input  logic        cmd_valid,
   input  logic [11:0] cmd_data,
   output logic        cmd_ready,
   input  logic [3:0]  target_sw,
   input  logic        vsync,
   output logic [11:0] location,
   output logic [5:0]  orientation,
   output logic [11:0] move_command,
   output logic [3:0]  target_location,
   output logic        new_data,
   output logic        stale,
   output logic        overrun
);

   localparam logic [7:0] STALE_MAX = 8'(STALE_FRAMES);

   typedef enum logic [1:0] {
      OPEN   = 2'd0,
      COMMIT = 2'd1,
      PULSE  = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;

   logic        ptr;          // 1: location was granted last, favour command
   logic [11:0] loc_shadow;
   logic [5:0]  ori_shadow;
   logic [11:0] cmd_shadow;
   logic        loc_pend;
   logic        cmd_pend;
   logic [3:0]  tgt_meta;
   logic [3:0]  tgt_sync;
   logic        vs1;
   logic        vs2;
   logic        fall;
   logic [7:0]  stale_cnt;
   logic        loc_acc;
   logic        cmd_acc;
   logic        chg;

   assign loc_acc = loc_valid & loc_ready;
   assign cmd_acc = cmd_valid & cmd_ready;
   assign chg     = loc_pend | cmd_pend | (tgt_sync != target_location);

   // Next-state and handshake readies.
   always_comb begin
      state_next = state;
      loc_ready  = 1'b0;
      cmd_ready  = 1'b0;
      case (state)
         OPEN: begin
            if (loc_valid && cmd_valid) begin
               if (ptr) begin
                  cmd_ready = 1'b1;
               end else begin
                  loc_ready = 1'b1;
               end
            end else begin
               loc_ready = loc_valid;
               cmd_ready = cmd_valid;
            end
            if (fall) begin
               state_next = COMMIT;
            end else begin
               state_next = OPEN;
            end
         end
         COMMIT:  state_next = PULSE;
         PULSE:   state_next = OPEN;
         default: state_next = OPEN;
      endcase
   end

   // State register.
   always_ff @(posedge vclock or posedge reset) begin
      if (reset) begin
         state <= OPEN;
      end else begin
         state <= state_next;
      end
   end

   // vsync edge detector; the falling-edge flag is registered so COMMIT is
   // entered two edges after vsync is first sampled low.
   always_ff @(posedge vclock or posedge reset) begin
      if (reset) begin
         vs1  <= 1'b1;
         vs2  <= 1'b1;
         fall <= 1'b0;
      end else begin
         vs1  <= vsync;
         vs2  <= vs1;
         fall <= vs2 & ~vs1;
      end
   end

   // Two-flop synchronizer for the asynchronous target switches.
   always_ff @(posedge vclock or posedge reset) begin
      if (reset) begin
         tgt_meta <= 4'd0;
         tgt_sync <= 4'd0;
      end else begin
         tgt_meta <= target_sw;
         tgt_sync <= tgt_meta;
      end
   end

   // Round-robin pointer remembers which requester was granted last.
   always_ff @(posedge vclock or posedge reset) begin
      if (reset) begin
         ptr <= 1'b0;
      end else if (loc_acc) begin
         ptr <= 1'b1;
      end else if (cmd_acc) begin
         ptr <= 1'b0;
      end else begin
         ptr <= ptr;
      end
   end

   // Shadow registers: latest accepted update of each kind wins.
   always_ff @(posedge vclock or posedge reset) begin
      if (reset) begin
         loc_shadow <= 12'd0;
         ori_shadow <= 6'd0;
         cmd_shadow <= 12'd0;
      end else begin
         if (loc_acc) begin
            loc_shadow <= loc_data;
            ori_shadow <= ori_data;
         end
         if (cmd_acc) begin
            cmd_shadow <= cmd_data;
         end
      end
   end

   // Pending flags and sticky overrun; accepts never coincide with COMMIT.
   always_ff @(posedge vclock or posedge reset) begin
      if (reset) begin
         loc_pend <= 1'b0;
         cmd_pend <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         if (state == COMMIT) begin
            loc_pend <= 1'b0;
            cmd_pend <= 1'b0;
         end else begin
            loc_pend <= loc_pend | loc_acc;
            cmd_pend <= cmd_pend | cmd_acc;
         end
         overrun <= overrun | (loc_acc & loc_pend) | (cmd_acc & cmd_pend);
      end
   end

   // Committed snapshot and the change pulse that follows it.
   always_ff @(posedge vclock or posedge reset) begin
      if (reset) begin
         location        <= 12'd0;
         orientation     <= 6'd0;
         move_command    <= 12'd0;
         target_location <= 4'd0;
         new_data        <= 1'b0;
      end else if (state == COMMIT) begin
         if (loc_pend) begin
            location    <= loc_shadow;
            orientation <= ori_shadow;
         end
         if (cmd_pend) begin
            move_command <= cmd_shadow;
         end
         target_location <= tgt_sync;
         new_data        <= chg;
      end else begin
         new_data <= 1'b0;
      end
   end

   // Frames since the last location commit, saturating, never wrapping.
   always_ff @(posedge vclock or posedge reset) begin
      if (reset) begin
         stale_cnt <= STALE_MAX;
      end else if (state == COMMIT) begin
         if (loc_pend) begin
            stale_cnt <= 8'd0;
         end else if (stale_cnt >= STALE_MAX) begin
            stale_cnt <= STALE_MAX;
         end else begin
            stale_cnt <= stale_cnt + 8'd1;
         end
      end else begin
         stale_cnt <= stale_cnt;
      end
   end

   // Registered staleness flag.
   always_ff @(posedge vclock or posedge reset) begin
      if (reset) begin
         stale <= 1'b1;
      end else begin
         stale <= (stale_cnt == STALE_MAX);
      end
   end

endmodule

// File: tb/tb_rover_display_sequencer.sv
// Directed testbench for rover_display_sequencer (STALE_FRAMES = 3).
module tb_rover_display_sequencer;

   logic        vclock = 1'b0;
   logic        reset = 1'b1;
   logic        loc_valid = 1'b0;
   logic [11:0] loc_data = 12'd0;
   logic [5:0]  ori_data = 6'd0;
   logic        loc_ready;
   logic        cmd_valid = 1'b0;
   logic [11:0] cmd_data = 12'd0;
   logic        cmd_ready;
   logic [3:0]  target_sw = 4'd0;
   logic        vsync = 1'b1;
   logic [11:0] location;
   logic [5:0]  orientation;
   logic [11:0] move_command;
   logic [3:0]  target_location;
   logic        new_data;
   logic        stale;
   logic        overrun;

   int vectors = 0;
   int miscompares = 0;

   rover_display_sequencer #(.STALE_FRAMES(3)) dut (
      .vclock(vclock), .reset(reset),
      .loc_valid(loc_valid), .loc_data(loc_data), .ori_data(ori_data), .loc_ready(loc_ready),
      .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
      .target_sw(target_sw), .vsync(vsync),
      .location(location), .orientation(orientation), .move_command(move_command),
      .target_location(target_location), .new_data(new_data), .stale(stale), .overrun(overrun)
   );

   always #5 vclock = ~vclock;

   task automatic apply_reset;
      reset = 1'b1; loc_valid = 1'b0; cmd_valid = 1'b0; vsync = 1'b1; target_sw = 4'd0;
      repeat (2) @(negedge vclock);
      reset = 1'b0;
      repeat (3) @(negedge vclock);
   endtask

   // One vsync low period; counts new_data pulses seen while it runs.
   task automatic frame(output int pulses);
      pulses = 0;
      @(negedge vclock); vsync = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge vclock);
         if (new_data) pulses++;
      end
      vsync = 1'b1;
      repeat (3) @(negedge vclock);
   endtask

   task automatic test_reset;
      apply_reset();
      vectors++; if (location !== 12'd0) begin miscompares++; $display("FAIL reset_location got %h want 000", location); end
      vectors++; if (orientation !== 6'd0) begin miscompares++; $display("FAIL reset_orientation got %0d want 0", orientation); end
      vectors++; if (move_command !== 12'd0) begin miscompares++; $display("FAIL reset_move got %h want 000", move_command); end
      vectors++; if (target_location !== 4'd0) begin miscompares++; $display("FAIL reset_target got %0d want 0", target_location); end
      vectors++; if (new_data !== 1'b0) begin miscompares++; $display("FAIL reset_new_data got %b want 0", new_data); end
      vectors++; if (stale !== 1'b1) begin miscompares++; $display("FAIL reset_stale got %b want 1", stale); end
      vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun got %b want 0", overrun); end
      vectors++; if ({loc_ready, cmd_ready} !== 2'b00) begin miscompares++; $display("FAIL reset_readies got %b want 00", {loc_ready, cmd_ready}); end
   endtask

   task automatic test_single_location;
      @(negedge vclock); loc_valid = 1'b1; loc_data = 12'h2A5; ori_data = 6'd17;
      #1;
      vectors++; if (loc_ready !== 1'b1) begin miscompares++; $display("FAIL single_loc_ready got %b want 1", loc_ready); end
      @(negedge vclock); loc_valid = 1'b0; vsync = 1'b0;   // next posedge is edge k
      @(negedge vclock);                                    // after k
      vectors++; if (location !== 12'd0) begin miscompares++; $display("FAIL single_early_k got %h want 000", location); end
      @(negedge vclock);                                    // after k+1
      @(negedge vclock);                                    // after k+2 (COMMIT)
      vectors++; if (location !== 12'd0) begin miscompares++; $display("FAIL single_early_k2 got %h want 000", location); end
      vectors++; if (new_data !== 1'b0) begin miscompares++; $display("FAIL single_nd_k2 got %b want 0", new_data); end
      @(negedge vclock);                                    // after k+3
      vectors++; if (location !== 12'h2A5) begin miscompares++; $display("FAIL single_location got %h want 2a5", location); end
      vectors++; if (orientation !== 6'd17) begin miscompares++; $display("FAIL single_orientation got %0d want 17", orientation); end
      vectors++; if (new_data !== 1'b1) begin miscompares++; $display("FAIL single_nd_k3 got %b want 1", new_data); end
      @(negedge vclock);                                    // after k+4
      vectors++; if (new_data !== 1'b0) begin miscompares++; $display("FAIL single_nd_k4 got %b want 0", new_data); end
      @(negedge vclock);
      vectors++; if (stale !== 1'b0) begin miscompares++; $display("FAIL single_stale got %b want 0", stale); end
      vsync = 1'b1;
      repeat (3) @(negedge vclock);
   endtask

   task automatic test_simultaneous;
      int p;
      apply_reset();
      loc_valid = 1'b1; loc_data = 12'h111; ori_data = 6'd1;
      cmd_valid = 1'b1; cmd_data = 12'hA01;
      #1;
      vectors++; if ({loc_ready, cmd_ready} !== 2'b10) begin miscompares++; $display("FAIL rr_grant1 got %b want 10", {loc_ready, cmd_ready}); end
      @(negedge vclock); loc_data = 12'h222; ori_data = 6'd2;
      #1;
      vectors++; if ({loc_ready, cmd_ready} !== 2'b01) begin miscompares++; $display("FAIL rr_grant2 got %b want 01", {loc_ready, cmd_ready}); end
      @(negedge vclock); cmd_data = 12'hA02;
      #1;
      vectors++; if ({loc_ready, cmd_ready} !== 2'b10) begin miscompares++; $display("FAIL rr_grant3 got %b want 10", {loc_ready, cmd_ready}); end
      vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL rr_overrun_early got %b want 0", overrun); end
      @(negedge vclock); loc_data = 12'h333; ori_data = 6'd3;
      #1;
      vectors++; if ({loc_ready, cmd_ready} !== 2'b01) begin miscompares++; $display("FAIL rr_grant4 got %b want 01", {loc_ready, cmd_ready}); end
      vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL rr_overrun got %b want 1", overrun); end
      @(negedge vclock); loc_valid = 1'b0; cmd_valid = 1'b0;
      frame(p);
      vectors++; if (location !== 12'h222) begin miscompares++; $display("FAIL rr_location got %h want 222", location); end
      vectors++; if (orientation !== 6'd2) begin miscompares++; $display("FAIL rr_orientation got %0d want 2", orientation); end
      vectors++; if (move_command !== 12'hA02) begin miscompares++; $display("FAIL rr_move got %h want a02", move_command); end
      vectors++; if (p !== 1) begin miscompares++; $display("FAIL rr_pulses got %0d want 1", p); end
   endtask

   task automatic test_quiet_frames;
      int p;
      target_sw = 4'd9;
      repeat (3) @(negedge vclock);
      frame(p);
      vectors++; if (target_location !== 4'd9) begin miscompares++; $display("FAIL quiet_target got %0d want 9", target_location); end
      vectors++; if (p !== 1) begin miscompares++; $display("FAIL quiet_pulse1 got %0d want 1", p); end
      frame(p);
      vectors++; if (p !== 0) begin miscompares++; $display("FAIL quiet_pulse2 got %0d want 0", p); end
      frame(p);
      vectors++; if (p !== 0) begin miscompares++; $display("FAIL quiet_pulse3 got %0d want 0", p); end
   endtask

   task automatic test_staleness;
      int p;
      @(negedge vclock); loc_valid = 1'b1; loc_data = 12'h456; ori_data = 6'd9;
      @(negedge vclock); loc_valid = 1'b0;
      frame(p);
      vectors++; if (stale !== 1'b0) begin miscompares++; $display("FAIL stale_after_loc got %b want 0", stale); end
      frame(p);
      vectors++; if (stale !== 1'b0) begin miscompares++; $display("FAIL stale_empty1 got %b want 0", stale); end
      frame(p);
      vectors++; if (stale !== 1'b0) begin miscompares++; $display("FAIL stale_empty2 got %b want 0", stale); end
      frame(p);
      vectors++; if (stale !== 1'b1) begin miscompares++; $display("FAIL stale_empty3 got %b want 1", stale); end
      @(negedge vclock); loc_valid = 1'b1; loc_data = 12'h457; ori_data = 6'd10;
      @(negedge vclock); loc_valid = 1'b0;
      frame(p);
      vectors++; if (stale !== 1'b0) begin miscompares++; $display("FAIL stale_refresh got %b want 0", stale); end
      vectors++; if (location !== 12'h457) begin miscompares++; $display("FAIL stale_location got %h want 457", location); end
   endtask

   task automatic test_reset_mid_operation;
      int p;
      target_sw = 4'd0;
      @(negedge vclock); cmd_valid = 1'b1; cmd_data = 12'hBEE;
      @(negedge vclock); cmd_valid = 1'b0; vsync = 1'b0;   // next posedge is edge k
      repeat (3) @(negedge vclock);                         // in COMMIT, cmd pending
      reset = 1'b1;
      #1;
      vectors++; if (location !== 12'd0) begin miscompares++; $display("FAIL midrst_location got %h want 000", location); end
      vectors++; if (orientation !== 6'd0) begin miscompares++; $display("FAIL midrst_orientation got %0d want 0", orientation); end
      vectors++; if (target_location !== 4'd0) begin miscompares++; $display("FAIL midrst_target got %0d want 0", target_location); end
      vectors++; if (stale !== 1'b1) begin miscompares++; $display("FAIL midrst_stale got %b want 1", stale); end
      vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL midrst_overrun got %b want 0", overrun); end
      @(negedge vclock); reset = 1'b0; vsync = 1'b1;
      repeat (3) @(negedge vclock);
      frame(p);
      vectors++; if (p !== 0) begin miscompares++; $display("FAIL midrst_pulses got %0d want 0", p); end
      vectors++; if (move_command !== 12'd0) begin miscompares++; $display("FAIL midrst_move got %h want 000", move_command); end
   endtask

   task automatic test_held_vsync;
      int lows;
      int pulses;
      lows = 0; pulses = 0;
      @(negedge vclock); loc_valid = 1'b1; loc_data = 12'h7C3; ori_data = 6'd33; vsync = 1'b0;
      for (int i = 0; i < 100; i++) begin
         #1;
         if (!loc_ready) lows++;
         @(negedge vclock);
         if (new_data) pulses++;
      end
      loc_valid = 1'b0; vsync = 1'b1;
      repeat (3) @(negedge vclock);
      vectors++; if (lows !== 2) begin miscompares++; $display("FAIL held_ready_low got %0d want 2", lows); end
      vectors++; if (pulses !== 1) begin miscompares++; $display("FAIL held_commits got %0d want 1", pulses); end
      vectors++; if (location !== 12'h7C3) begin miscompares++; $display("FAIL held_location got %h want 7c3", location); end
   endtask

   initial begin
      test_reset();
      test_single_location();
      test_simultaneous();
      test_quiet_frames();
      test_staleness();
      test_reset_mid_operation();
      test_held_vsync();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/rover_display_sequencer.md
# rover_display_sequencer

Frame-synchronous update controller for the rover display path. It accepts rover location/orientation updates from the location solver and move commands from the path planner over valid/ready handshakes, and arbitrates between them when both arrive together. It buffers the updates in shadow registers and commits one coherent snapshot to the VGA writer at the start of each vertical sync, so a frame never mixes old and new data. It also tracks location staleness for on-screen warning.

## Interface
- `STALE_FRAMES`, default 60: frames without a location commit before `stale` asserts (≤255).
- `vclock` in 1: 65 MHz pixel clock.
- `reset` in 1: asynchronous, active-high; clears all state.
- `loc_valid` in 1: location solver has an update.
- `loc_data` in 12: rover location.
- `ori_data` in 6: rover orientation, paired with `loc_data`.
- `loc_ready` out 1: location update accepted this cycle when `loc_valid` is also high.
- `cmd_valid` in 1: planner has a move command.
- `cmd_data` in 12: move command.
- `cmd_ready` out 1: command accepted this cycle when `cmd_valid` is also high.
- `target_sw` in 4: raw target-location switches (asynchronous).
- `vsync` in 1: XVGA vertical sync, active low, generated in the `vclock` domain.
- `location` out 12: committed location to the VGA writer.
- `orientation` out 6: committed orientation.
- `move_command` out 12: committed move command.
- `target_location` out 4: committed target.
- `new_data` out 1: one-cycle pulse when any committed field changed source.
- `stale` out 1: location not refreshed for `STALE_FRAMES` frames.
- `overrun` out 1: sticky; an accepted update overwrote an uncommitted one.

## Operation
- **FSM states:** OPEN, COMMIT, PULSE. Reset state is OPEN.
- **OPEN:**
  - Handshakes are enabled.
  - If only one valid is high, that requester's ready is high.
  - If both are high, ready goes only to the requester not granted last. The round-robin pointer resets to favour location and flips on every grant.
  - Both readies are low in COMMIT and PULSE.
  - Ready is combinational from the state, valids and pointer; producers hold valid and data until ready.
- **Accept:** on a location accept, `loc_data`/`ori_data` load the shadow and set `loc_pend`. On a command accept, `cmd_data` loads the shadow and sets `cmd_pend`.
- **Overwrite:** a second accept of the same kind before commit overwrites the shadow (latest wins) and sets `overrun`. `overrun` clears only on reset.
- **Target switches:** `target_sw` passes through a 2-flop synchronizer into `tgt_sync`.
- **vsync edge detect:** `vsync` is registered twice (`vs1`, `vs2`). `fall = vs2 & ~vs1`. On `fall` in OPEN, go to COMMIT.
- **COMMIT (1 cycle):**
  - Each pending field copies from shadow to its output.
  - `target_location` <= `tgt_sync`.
  - `chg = loc_pend | cmd_pend | (tgt_sync != target_location)`.
  - Pending flags clear.
  - Stale counter: zero if `loc_pend`, else increment, saturating at `STALE_FRAMES`.
  - Go to PULSE.
- **PULSE (1 cycle):** `new_data` = registered `chg`. Go to OPEN.
- **`stale`:** registered, equal to (counter == `STALE_FRAMES`).

## Timing
- **Reset values:** all outputs 0 except `stale` = 1. Counter = `STALE_FRAMES`; shadows, pending flags and pointer are zero; `vs1`/`vs2` = 1.
- **Reset mid-operation:** everything clears immediately, whatever the state, and any pending update is lost.
- **Commit timing:** if `vsync` is first sampled low at edge k, the state is COMMIT after edge k+2. Outputs change at edge k+3. `new_data` is high for the cycle following edge k+3 only.
- **Late accept:** an accept on the edge that enters COMMIT (edge k+2) is included in that frame's commit.
- **Readies low:** for exactly 2 cycles per frame.
- **Frame count:** one commit per `vsync` falling edge. Holding `vsync` low produces no further commits.
- **Quiet frame:** with no pending data and an unchanged target, COMMIT still runs (stale counting) but `new_data` stays 0.
- **Counter width:** 8 bits; saturates and never wraps.

## Test plan
- **Single location update:** reset, then `loc_valid` with `loc_data`=12'h2A5, `ori_data`=6'd17, then one `vsync` fall.
  - `loc_ready` is high in the same cycle.
  - `location`=12'h2A5 and `orientation`=17 at edge k+3.
  - `new_data` is high for exactly 1 cycle.
  - `stale` = 0 after the commit.
- **Simultaneous requests:** `loc_valid` and `cmd_valid` both held high from reset.
  - Grants go loc, cmd, loc, cmd on consecutive cycles.
  - `overrun` = 1 by the third grant.
  - The committed value is the last accepted of each kind.
- **Quiet frames:** no updates, toggle `target_sw` 0→9, then 3 vsync falls.
  - `target_location`=9 after the first commit, with `new_data` pulsed once.
  - The next two frames show no `new_data` pulse.
- **Staleness:** `STALE_FRAMES`=3, commit one location, then 3 frames without one.
  - `stale` rises after the 3rd empty commit.
  - The next location commit drops it to 0.
- **Reset mid-operation:** assert `reset` while in COMMIT with `cmd_pend`=1.
  - All outputs return to reset values within the cycle.
  - The next frame commits nothing and `new_data` stays 0.
- **Held vsync:** hold `vsync` low for 100 cycles.
  - Exactly one commit occurs.
  - Readies are low for exactly 2 cycles.
